wb_stage: RTL

Writeback stage sitting directly upstream of the register file write port. It merges ALU results and variable-latency memory load returns into a single registered write (WriteEn/Waddr/DataIn) and tracks outstanding load destinations in an in-order load queue. It raises Stall toward decode on read-after-write hazards and back-pressure.

---
 rtl/wb_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback merge point ahead of the register file write port.
// Load returns, a one-entry ALU skid buffer and fresh ALU results compete for
// a single registered write. An in-order load queue tracks outstanding load
// destinations so that decode can be stalled on read-after-write hazards.
// Optional feature macro: WB_BYPASS_EN. When it is defined, the in-flight
// write is forwarded to decode instead of being treated as busy.
module wb_stage #(
  parameter int W        = 8,
  parameter int A        = 4,
  parameter int LQ_DEPTH = 2
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic         AluValid_i,
  input  logic [A-1:0] AluWaddr_i,
  input  logic [W-1:0] AluData_i,
  output logic         AluReady_o,
  input  logic         LdIssue_i,
  input  logic [A-1:0] LdWaddr_i,
  output logic         LdReady_o,
  input  logic         MemValid_i,
  input  logic [W-1:0] MemData_i,
  input  logic [A-1:0] RaddrA_i,
  input  logic [A-1:0] RaddrB_i,
  input  logic [A-1:0] DestAddr_i,
  output logic         Stall_o,
  output logic         WriteEn_o,
  output logic [A-1:0] Waddr_o,
  output logic [W-1:0] DataIn_o,
  output logic         FwdEnA_o,
  output logic         FwdEnB_o,
  output logic [W-1:0] FwdData_o
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int NR = 2 ** A;

  // Load queue storage: per-slot valid bit and destination address
  logic [LQ_DEPTH-1:0] lq_vld_q;
  logic [A-1:0]        lq_addr_q [LQ_DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW:0]         cnt_q;
  logic [PW:0]         cnt_d;

  // Skid buffer holding one ALU result that lost arbitration to a load
  logic                skid_vld_q;
  logic [A-1:0]        skid_addr_q;
  logic [W-1:0]        skid_data_q;

  // Registered write port
  logic                wen_q;
  logic [A-1:0]        waddr_q;
  logic [W-1:0]        wdata_q;

  logic                ld_ready;
  logic                lq_push;
  logic                lq_pop;
  logic [A-1:0]        lq_head_addr;
  logic [NR-1:0]       lq_busy;
  logic [NR-1:0]       wr_busy;
  logic [NR-1:0]       busy;

  // A full queue refuses new loads even when a pop happens in the same cycle;
  // a return with nothing outstanding is stray and ignored.
  assign ld_ready     = (cnt_q != (PW+1)'(LQ_DEPTH));
  assign lq_push      = LdIssue_i && ld_ready;
  assign lq_pop       = MemValid_i && (cnt_q != '0);
  assign lq_head_addr = lq_addr_q[rd_ptr_q];

  // A register is busy while any valid queue slot names it; duplicates keep
  // it busy until the last matching load has returned.
  for (genvar gi = 0; gi < NR; gi++) begin : g_busy
    logic [LQ_DEPTH-1:0] hit;
    for (genvar gj = 0; gj < LQ_DEPTH; gj++) begin : g_slot
      assign hit[gj] = lq_vld_q[gj] && (lq_addr_q[gj] == A'(gi));
    end
    assign lq_busy[gi] = |hit;
  end

`ifdef WB_BYPASS_EN
  // The write in flight is forwarded, so it never counts as busy.
  assign wr_busy   = '0;
  assign FwdEnA_o  = wen_q && (waddr_q == RaddrA_i);
  assign FwdEnB_o  = wen_q && (waddr_q == RaddrB_i);
  assign FwdData_o = wdata_q;
`else
  // No forwarding path: decode must also wait out the write in flight.
  assign wr_busy   = wen_q ? (NR'(1) << waddr_q) : '0;
  assign FwdEnA_o  = 1'b0;
  assign FwdEnB_o  = 1'b0;
  assign FwdData_o = '0;
`endif

  assign busy = lq_busy | wr_busy;

  assign AluReady_o = !skid_vld_q;
  assign LdReady_o  = ld_ready;
  assign Stall_o    = busy[RaddrA_i] | busy[RaddrB_i] | busy[DestAddr_i]
                    | skid_vld_q | !ld_ready;

  assign WriteEn_o = wen_q;
  assign Waddr_o   = waddr_q;
  assign DataIn_o  = wdata_q;

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (lq_push && !lq_pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (!lq_push && lq_pop) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Load queue: push at tail on accepted issue, retire head on return
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      lq_vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (lq_pop) begin
        lq_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      if (lq_push) begin
        lq_vld_q[wr_ptr_q]  <= 1'b1;
        lq_addr_q[wr_ptr_q] <= LdWaddr_i;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Skid buffer: captures an accepted ALU result that lost to a load return,
  // drains on the first cycle without a load return
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      skid_vld_q  <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else if (skid_vld_q) begin
      if (!lq_pop) begin
        skid_vld_q <= 1'b0;
      end
    end else if (AluValid_i && lq_pop) begin
      skid_vld_q  <= 1'b1;
      skid_addr_q <= AluWaddr_i;
      skid_data_q <= AluData_i;
    end
  end

  // Write arbitration: load return, then skid buffer, then fresh ALU result
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (lq_pop) begin
      wen_q   <= 1'b1;
      waddr_q <= lq_head_addr;
      wdata_q <= MemData_i;
    end else if (skid_vld_q) begin
      wen_q   <= 1'b1;
      waddr_q <= skid_addr_q;
      wdata_q <= skid_data_q;
    end else if (AluValid_i) begin
      wen_q   <= 1'b1;
      waddr_q <= AluWaddr_i;
      wdata_q <= AluData_i;
    end else begin
      wen_q   <= 1'b0;
    end
  end

endmodule
